// File: rtl/if_id_skid_stage_pkg.sv
// Shared definitions for the IF->ID pipeline stage: defaults, stage state encoding and helpers.
package if_id_skid_stage_pkg;

  localparam logic [31:0] BUBBLE_INSTR_DEFAULT = 32'h0000_0000;

  typedef logic [1:0] stage_state_t;

  localparam stage_state_t ST_EMPTY = 2'd0;
  localparam stage_state_t ST_ONE   = 2'd1;
  localparam stage_state_t ST_FULL  = 2'd2;

  // Entries held in a given stage state.
  function automatic logic [1:0] state_occupancy(input stage_state_t st);
    logic [1:0] occ;
    occ = 2'd0;
    if (st == ST_ONE) occ = 2'd1;
    if (st == ST_FULL) occ = 2'd2;
    return occ;
  endfunction

endpackage

// File: rtl/if_id_skid_stage_if.sv
// Handshake bundle between fetch, the IF->ID stage and decode, plus stage controls.
interface if_id_skid_stage_if #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned PC_WIDTH    = 32
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] in_instruction;
  logic [PC_WIDTH-1:0]    in_pc;
  logic                   stall;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instruction;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [1:0]             occupancy;

  modport master (
    output in_valid, in_instruction, in_pc, stall, flush, out_ready,
    input  in_ready, out_valid, out_instruction, out_pc, occupancy
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, stall, flush, out_ready,
    output in_ready, out_valid, out_instruction, out_pc, occupancy
  );

endinterface

// File: rtl/if_id_skid_stage_entry_reg.sv
// One pipeline entry: valid flag plus instruction and PC, with load and clear (clear wins).
module pipe_entry_reg #(
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter int unsigned          PC_WIDTH    = 32,
  parameter logic [INSTR_WIDTH-1:0] INSTR_RESET = '0,
  parameter logic [PC_WIDTH-1:0]    PC_RESET    = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_load,
  input  logic                   i_clear,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [PC_WIDTH-1:0]    i_pc,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [PC_WIDTH-1:0]    o_pc
);

  logic                   r_valid;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]    r_pc;

  // Clearing only drops valid so the last PC stays visible downstream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_instr <= INSTR_RESET;
      r_pc    <= PC_RESET;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage with optional 2-entry skid buffer, stall (bubble + hold) and flush.
module if_id_skid_stage
  import if_id_skid_stage_pkg::*;
#(
  parameter int unsigned            INSTR_WIDTH  = 32,
  parameter int unsigned            PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]    PC_RESET     = {PC_WIDTH{1'b1}} << 2,
  parameter logic [INSTR_WIDTH-1:0] BUBBLE_INSTR = INSTR_WIDTH'(BUBBLE_INSTR_DEFAULT),
  parameter bit                     SKID         = 1'b1
) (
  input logic               clock,
  input logic               reset_n,
  if_id_skid_stage_if.slave bus
);

  stage_state_t           r_state, w_state_next;
  logic                   r_in_ready, w_in_ready;
  logic                   w_in_fire, w_out_fire, w_out_valid;
  logic                   w_m_load, w_m_clear, w_m_from_skid, w_s_load, w_s_clear;
  logic                   w_m_valid, w_s_valid;
  logic [INSTR_WIDTH-1:0] w_m_instr, w_s_instr, w_m_d_instr;
  logic [PC_WIDTH-1:0]    w_m_pc, w_s_pc, w_m_d_pc;

  assign w_out_valid = w_m_valid & ~bus.stall;
  assign w_out_fire  = w_out_valid & bus.out_ready;
  assign w_in_ready  = SKID ? r_in_ready : (~w_m_valid | w_out_fire);
  assign w_in_fire   = bus.in_valid & w_in_ready & ~bus.flush;

  always_comb begin
    w_state_next  = r_state;
    w_m_load      = 1'b0;
    w_m_clear     = 1'b0;
    w_m_from_skid = 1'b0;
    w_s_load      = 1'b0;
    w_s_clear     = 1'b0;
    if (bus.flush) begin
      w_state_next = ST_EMPTY;
      w_m_clear    = 1'b1;
      w_s_clear    = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_next = ST_ONE;
            w_m_load     = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_m_load = 1'b1;
          end else if (w_out_fire) begin
            w_state_next = ST_EMPTY;
            w_m_clear    = 1'b1;
          end else if (w_in_fire && SKID) begin
            // Younger beat parks in S; M keeps the older one.
            w_state_next = ST_FULL;
            w_s_load     = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_next  = ST_ONE;
            w_m_load      = 1'b1;
            w_m_from_skid = 1'b1;
            w_s_clear     = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
          w_m_clear    = 1'b1;
          w_s_clear    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != ST_FULL);
    end
  end

  assign w_m_d_instr = w_m_from_skid ? w_s_instr : bus.in_instruction;
  assign w_m_d_pc    = w_m_from_skid ? w_s_pc : bus.in_pc;

  pipe_entry_reg #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_RESET (BUBBLE_INSTR),
    .PC_RESET    (PC_RESET)
  ) u_main (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_m_load),
    .i_clear (w_m_clear),
    .i_instr (w_m_d_instr),
    .i_pc    (w_m_d_pc),
    .o_valid (w_m_valid),
    .o_instr (w_m_instr),
    .o_pc    (w_m_pc)
  );

  if (SKID) begin : g_skid
    pipe_entry_reg #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_RESET (BUBBLE_INSTR),
      .PC_RESET    (PC_RESET)
    ) u_skid (
      .clock   (clock),
      .reset_n (reset_n),
      .i_load  (w_s_load),
      .i_clear (w_s_clear),
      .i_instr (bus.in_instruction),
      .i_pc    (bus.in_pc),
      .o_valid (w_s_valid),
      .o_instr (w_s_instr),
      .o_pc    (w_s_pc)
    );
  end else begin : g_no_skid
    assign w_s_valid = 1'b0;
    assign w_s_instr = BUBBLE_INSTR;
    assign w_s_pc    = PC_RESET;
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = w_out_valid;
  assign bus.out_instruction = w_out_valid ? w_m_instr : BUBBLE_INSTR;
  assign bus.out_pc          = w_m_pc;
  assign bus.occupancy       = state_occupancy(r_state);

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: SKID=1 instance for most scenarios, SKID=0 instance for comb ready.
module tb_if_id_skid_stage;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  always #5 clock = ~clock;

  if_id_skid_stage_if #(.INSTR_WIDTH(32), .PC_WIDTH(32)) bus1 ();
  if_id_skid_stage_if #(.INSTR_WIDTH(32), .PC_WIDTH(32)) bus0 ();

  if_id_skid_stage #(.INSTR_WIDTH(32), .PC_WIDTH(32), .SKID(1'b1)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  if_id_skid_stage #(.INSTR_WIDTH(32), .PC_WIDTH(32), .SKID(1'b0)) u_dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic idle_all();
    bus1.in_valid = 1'b0; bus1.in_pc = '0; bus1.in_instruction = '0;
    bus1.stall = 1'b0; bus1.flush = 1'b0; bus1.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_pc = '0; bus0.in_instruction = '0;
    bus0.stall = 1'b0; bus0.flush = 1'b0; bus0.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      bus1.in_valid = 1'b1; bus1.out_ready = 1'b0;
      bus1.in_pc = 32'h100 + 32'(4 * i); bus1.in_instruction = instr_of(bus1.in_pc);
    end
    @(posedge clock); #1;
    bus1.in_valid = 1'b0;
    #1;
    n_vec++;
    if (bus1.occupancy !== 2'd2) begin
      n_err++; $display("FAIL reset_pre occupancy got %0d want 2", bus1.occupancy);
    end
    #1 reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus1.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset out_valid got %b want 0", bus1.out_valid);
    end
    n_vec++;
    if (bus1.out_instruction !== 32'h0) begin
      n_err++; $display("FAIL reset out_instruction got %h want 0", bus1.out_instruction);
    end
    n_vec++;
    if (bus1.out_pc !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL reset out_pc got %h want fffffffc", bus1.out_pc);
    end
    n_vec++;
    if (bus1.occupancy !== 2'd0) begin
      n_err++; $display("FAIL reset occupancy got %0d want 0", bus1.occupancy);
    end
    n_vec++;
    if (bus1.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset in_ready got %b want 1", bus1.in_ready);
    end
    n_vec++;
    if (bus0.out_pc !== 32'hFFFF_FFFC || bus0.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset skid0 out_pc/in_ready got %h/%b want fffffffc/1",
                        bus0.out_pc, bus0.in_ready);
    end
    bus1.out_ready = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      bus1.in_valid = (i < 3); bus1.out_ready = 1'b1;
      bus1.in_pc = 32'(4 * i); bus1.in_instruction = instr_of(bus1.in_pc);
      #1;
      n_vec++;
      if (bus1.in_ready !== 1'b1) begin
        n_err++; $display("FAIL stream in_ready cyc%0d got %b want 1", i, bus1.in_ready);
      end
      if (i >= 1 && i <= 3) begin
        pc = 32'(4 * (i - 1));
        n_vec++;
        if (bus1.out_valid !== 1'b1 || bus1.out_pc !== pc || bus1.out_instruction !== instr_of(pc))
        begin
          n_err++; $display("FAIL stream beat cyc%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                            i, bus1.out_valid, bus1.out_pc, bus1.out_instruction, pc, instr_of(pc));
        end
      end else begin
        n_vec++;
        if (bus1.out_valid !== 1'b0 || bus1.out_instruction !== 32'h0) begin
          n_err++; $display("FAIL stream idle cyc%0d got v=%b ins=%h want v=0 ins=0",
                            i, bus1.out_valid, bus1.out_instruction);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit          in_v  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] in_pc [8] = '{32'h10, 32'h14, 32'h18, 32'h18, 32'h18, 32'h18, 32'h0, 32'h0};
    bit          ordy  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit          e_rdy [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]  e_occ [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    bit          e_ov  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] e_pc  [8] = '{32'h08, 32'h10, 32'h10, 32'h10, 32'h10, 32'h14, 32'h18, 32'h18};
    logic [31:0] e_ins;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      bus1.in_valid = in_v[i]; bus1.in_pc = in_pc[i]; bus1.in_instruction = instr_of(in_pc[i]);
      bus1.out_ready = ordy[i];
      #1;
      e_ins = e_ov[i] ? instr_of(e_pc[i]) : 32'h0;
      n_vec++;
      if (bus1.in_ready !== e_rdy[i] || bus1.occupancy !== e_occ[i]) begin
        n_err++; $display("FAIL bp ready/occ cyc%0d got %b/%0d want %b/%0d",
                          i, bus1.in_ready, bus1.occupancy, e_rdy[i], e_occ[i]);
      end
      n_vec++;
      if (bus1.out_valid !== e_ov[i] || bus1.out_pc !== e_pc[i] || bus1.out_instruction !== e_ins)
      begin
        n_err++; $display("FAIL bp out cyc%0d got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h", i,
                          bus1.out_valid, bus1.out_pc, bus1.out_instruction, e_ov[i], e_pc[i], e_ins);
      end
    end
  endtask

  task automatic test_stall();
    bit          in_v  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit          stl   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit          e_ov  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] e_pc  [6] = '{32'h18, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20};
    logic [1:0]  e_occ [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [31:0] e_ins;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      bus1.in_valid = in_v[i]; bus1.in_pc = 32'h20; bus1.in_instruction = instr_of(32'h20);
      bus1.stall = stl[i]; bus1.out_ready = 1'b1;
      #1;
      e_ins = e_ov[i] ? instr_of(e_pc[i]) : 32'h0;
      n_vec++;
      if (bus1.out_valid !== e_ov[i] || bus1.out_pc !== e_pc[i] || bus1.out_instruction !== e_ins)
      begin
        n_err++; $display("FAIL stall out cyc%0d got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h", i,
                          bus1.out_valid, bus1.out_pc, bus1.out_instruction, e_ov[i], e_pc[i], e_ins);
      end
      n_vec++;
      if (bus1.occupancy !== e_occ[i] || bus1.in_ready !== 1'b1) begin
        n_err++; $display("FAIL stall occ/ready cyc%0d got %0d/%b want %0d/1",
                          i, bus1.occupancy, bus1.in_ready, e_occ[i]);
      end
    end
    bus1.stall = 1'b0;
  endtask

  task automatic test_flush();
    bit          in_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] in_pc [6] = '{32'h28, 32'h2C, 32'h30, 32'h34, 32'h0, 32'h0};
    bit          ordy  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit          stl   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit          fl    [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit          e_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]  e_occ [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    bit          e_ov  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] e_pc  [6] = '{32'h20, 32'h28, 32'h28, 32'h28, 32'h28, 32'h28};
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      bus1.in_valid = in_v[i]; bus1.in_pc = in_pc[i]; bus1.in_instruction = instr_of(in_pc[i]);
      bus1.out_ready = ordy[i]; bus1.stall = stl[i]; bus1.flush = fl[i];
      #1;
      n_vec++;
      if (bus1.in_ready !== e_rdy[i] || bus1.occupancy !== e_occ[i]) begin
        n_err++; $display("FAIL flush ready/occ cyc%0d got %b/%0d want %b/%0d",
                          i, bus1.in_ready, bus1.occupancy, e_rdy[i], e_occ[i]);
      end
      n_vec++;
      if (bus1.out_valid !== e_ov[i] || bus1.out_pc !== e_pc[i]) begin
        n_err++; $display("FAIL flush out cyc%0d got v=%b pc=%h want v=%b pc=%h",
                          i, bus1.out_valid, bus1.out_pc, e_ov[i], e_pc[i]);
      end
    end
    bus1.stall = 1'b0; bus1.flush = 1'b0;
  endtask

  task automatic test_skid0();
    @(posedge clock); #1;
    bus0.in_valid = 1'b1; bus0.in_pc = 32'h50; bus0.in_instruction = instr_of(32'h50);
    bus0.out_ready = 1'b0;
    #1;
    n_vec++;
    if (bus0.in_ready !== 1'b1 || bus0.occupancy !== 2'd0) begin
      n_err++; $display("FAIL skid0 empty ready/occ got %b/%0d want 1/0",
                        bus0.in_ready, bus0.occupancy);
    end
    @(posedge clock); #1;
    bus0.in_pc = 32'h54; bus0.in_instruction = instr_of(32'h54);
    #1;
    n_vec++;
    if (bus0.in_ready !== 1'b0) begin
      n_err++; $display("FAIL skid0 blocked in_ready got %b want 0", bus0.in_ready);
    end
    n_vec++;
    if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 32'h50 || bus0.occupancy !== 2'd1) begin
      n_err++; $display("FAIL skid0 full got v=%b pc=%h occ=%0d want v=1 pc=50 occ=1",
                        bus0.out_valid, bus0.out_pc, bus0.occupancy);
    end
    bus0.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus0.in_ready !== 1'b1) begin
      n_err++; $display("FAIL skid0 released in_ready got %b want 1", bus0.in_ready);
    end
    @(posedge clock); #1;
    bus0.in_valid = 1'b0;
    #1;
    n_vec++;
    if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 32'h54 || bus0.in_ready !== 1'b1) begin
      n_err++; $display("FAIL skid0 next got v=%b pc=%h rdy=%b want v=1 pc=54 rdy=1",
                        bus0.out_valid, bus0.out_pc, bus0.in_ready);
    end
    bus0.stall = 1'b1;
    #1;
    n_vec++;
    if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0) begin
      n_err++; $display("FAIL skid0 stall rdy/v got %b/%b want 0/0", bus0.in_ready, bus0.out_valid);
    end
    bus0.stall = 1'b0;
    @(posedge clock); #1;
    #1;
    n_vec++;
    if (bus0.out_valid !== 1'b0 || bus0.occupancy !== 2'd0) begin
      n_err++; $display("FAIL skid0 drained got v=%b occ=%0d want 0/0",
                        bus0.out_valid, bus0.occupancy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_skid0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
